cnt_arb_seq: RTL and testbench
==============================

Name: cnt_arb_seq

Overview:
- Round-robin arbiter and sequencer that shares one external up/down counter (count, load_en, load, down, rollover interface) among NREQ requesters.
- Each requester issues one command: LOAD a value, count UP by N steps, or count DOWN by N steps.
- The counter has no enable, so this block holds its value while idle by reloading the current count.
- Sits between the requesting agents and the counter instance.

Parameters:
WIDTH, 4, counter width
NREQ, 4, number of requesters (2..8)
STEPW, 4, width of per-request step count

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req_op  input  2*NREQ  per-requester op, slice [2i+1:2i]: 00 none, 01 LOAD, 10 UP, 11 DOWN
req_val  input  WIDTH*NREQ  per-requester LOAD value
req_steps  input  STEPW*NREQ  per-requester UP/DOWN step count
gnt  output  NREQ  one-hot grant
done  output  NREQ  one-hot, one-cycle completion pulse
busy  output  1  high when not IDLE
wrap  output  1  valid with done: counter wrapped (or saturated) during the op
cnt_count  input  WIDTH  current counter value
cnt_rollover  input  1  counter all-ones flag
cnt_load_en  output  1  to counter load_en
cnt_load  output  WIDTH  to counter load
cnt_down  output  1  to counter down

Behaviour:
- Reset is asynchronous and active-high; one clock, clk.
- Reset values:
  - state=IDLE, rr pointer=0.
  - gnt=0, done=0, busy=0, wrap=0.
  - cnt_down=0, cnt_load_en=1, cnt_load=cnt_count (hold).
- Outputs are Moore (state and registers only). Exception: cnt_load=cnt_count passthrough in hold cycles.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - Counter is held.
  - A requester is active if its op != 00.
  - Round-robin selection starts at the rr pointer.
  - On a clock edge with any active requester, latch owner, op, val and steps; set ptr=(owner+1) mod NREQ; go to RUN.
- RUN:
  - gnt[owner]=1, busy=1.
  - LOAD: one cycle with cnt_load_en=1, cnt_load=val. Then DONE.
  - UP/DOWN with steps=S>0:
    - S cycles with cnt_load_en=0 and cnt_down=(op==DOWN); a remaining-count register decrements each cycle.
    - Leave for DONE on the edge where remaining==1.
  - UP/DOWN with steps=0: one hold cycle, then DONE, counter unchanged.
- Wrap detection:
  - Set a sticky flag in any counting RUN cycle where op==UP and cnt_rollover=1, or op==DOWN and cnt_count==0.
  - The flag clears on entry to RUN.
- DONE:
  - Counter is held; gnt[owner]=1, done[owner]=1, wrap=flag; busy=1.
  - Always go to IDLE next.
- Latency:
  - Request sampled at edge k; RUN starts cycle k+1.
  - Counter shows the final value after S edges (1 for LOAD or steps=0).
  - done pulses in the following cycle.
  - Request-to-done is S+1 cycles after sampling.
  - Minimum gap between ops is one IDLE cycle.
- Requester protocol:
  - Hold op, val and steps stable from request until done.
  - Drop op on the edge after done, or the request is re-arbitrated as new.
  - Ops are sampled only in IDLE; changes at other times are ignored.
- Reset mid-op: the op is abandoned immediately. gnt and done drop with no done pulse; counter is held; ptr=0.
- Arithmetic is modulo 2^WIDTH in the counter. The step counter is STEPW bits, unsigned.

Optional Feature:
Macro CNT_ARB_SAT_EN.
- Defined:
  - UP/DOWN saturates. A counting RUN cycle where the next step would wrap (UP with cnt_rollover=1, DOWN with cnt_count==0) becomes a hold cycle instead, and the FSM goes to DONE on that edge.
  - wrap=1 with done means saturated early.
- Undefined: the counter wraps freely, the op always runs S steps, and wrap reports the wrap.

Test Plan:
1. Reset, no requests for 10 cycles -> cnt_load_en=1, count stays 0, busy=0, gnt=0.
2. Requester 1 LOAD val=9 -> gnt=0010 from the next cycle; count=9 after one RUN cycle; done=0010 pulse one cycle later; wrap=0.
3. Count=13, requester 2 UP steps=5 -> 5 RUN cycles; count=2; done[2] with wrap=1. With CNT_ARB_SAT_EN: count stops at 15 after 2 steps; done in DONE cycle; wrap=1.
4. After reset, requesters 1 and 2 both continuously request DOWN steps=1 -> grant order 1,2,1,2; each op takes 3 cycles; counts 0->15->14->13->12. No wrap, except wrap=1 on the first op (0->15) without SAT_EN.
5. Requester 3 UP steps=0, count=7 -> count stays 7; done[3] two cycles after sampling; wrap=0.
6. rst asserted in the 2nd RUN cycle of an UP steps=8 op -> gnt=0, busy=0 asynchronously; no done pulse. After release, a simultaneous request from 0 and 3 grants 0 first.

Source files
------------

// File: rtl/cnt_arb_seq_if.sv
// Requester and counter-side signals of the cnt_arb_seq block.
// The slave modport is the arbiter; the master modport is the requesters plus the counter.
interface cnt_arb_seq_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int STEPW = 4
);
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_val;
  logic [STEPW*NREQ-1:0] req_steps;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic                  wrap;
  logic [WIDTH-1:0]      cnt_count;
  logic                  cnt_rollover;
  logic                  cnt_load_en;
  logic [WIDTH-1:0]      cnt_load;
  logic                  cnt_down;

  modport master (
    output req_op, req_val, req_steps, cnt_count, cnt_rollover,
    input  gnt, done, busy, wrap, cnt_load_en, cnt_load, cnt_down
  );

  modport slave (
    input  req_op, req_val, req_steps, cnt_count, cnt_rollover,
    output gnt, done, busy, wrap, cnt_load_en, cnt_load, cnt_down
  );
endinterface

// File: rtl/cnt_arb_seq.sv
// Round-robin sequencer sharing one up/down counter; request-to-done is S+1 cycles, ops sampled only in IDLE.
// Requesters hold op until done (no other backpressure); define CNT_ARB_SAT_EN to saturate instead of wrap.
module cnt_arb_seq #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int STEPW = 4
) (
  input  logic          clk,
  input  logic          rst,
  cnt_arb_seq_if.slave  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     owner, ptr, sel;
  logic              sel_vld;
  logic [1:0]        op;
  logic [WIDTH-1:0]  val;
  logic [STEPW-1:0]  rem;
  logic              wflag;
  logic              counting;
  logic              wrap_cond;
  logic [NREQ-1:0]   owner_oh;

  // First active requester at or after ptr, scanning in round-robin order.
  always_comb begin : rr_pick
    int j;
    j       = 0;
    sel     = ptr;
    sel_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (bus.req_op[2*j +: 2] != 2'b00) begin
        sel     = IW'(j);
        sel_vld = 1'b1;
      end
    end
  end

  assign counting  = (state == RUN) && op[1] && (rem != '0);
  assign wrap_cond = ((op == OP_UP) && bus.cnt_rollover) ||
                     ((op == OP_DOWN) && (bus.cnt_count == '0));
  assign owner_oh  = NREQ'(1) << owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= '0;
      ptr   <= '0;
      op    <= 2'b00;
      val   <= '0;
      rem   <= '0;
      wflag <= 1'b0;
    end else if ((state == IDLE) && sel_vld) begin
      owner <= sel;
      ptr   <= (sel == IW'(NREQ - 1)) ? '0 : sel + 1'b1;
      op    <= bus.req_op[2*sel +: 2];
      val   <= bus.req_val[WIDTH*sel +: WIDTH];
      rem   <= bus.req_steps[STEPW*sel +: STEPW];
      wflag <= 1'b0;
    end else if (counting) begin
      rem <= rem - 1'b1;
      if (wrap_cond) begin
        wflag <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    bus.cnt_load_en = 1'b1;
    bus.cnt_load    = bus.cnt_count;
    bus.cnt_down    = 1'b0;
    bus.gnt         = (state != IDLE) ? owner_oh : '0;
    bus.done        = (state == DONE) ? owner_oh : '0;
    bus.busy        = (state != IDLE);
    bus.wrap        = (state == DONE) && wflag;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!counting) begin
          // LOAD, or a zero-step count that only holds for one cycle
          state_nxt = DONE;
          if (op == OP_LOAD) begin
            bus.cnt_load = val;
          end
        end else begin
`ifdef CNT_ARB_SAT_EN
          if (wrap_cond) begin
            state_nxt = DONE;
          end else begin
            bus.cnt_load_en = 1'b0;
            bus.cnt_down    = (op == OP_DOWN);
            if (rem == STEPW'(1)) begin
              state_nxt = DONE;
            end
          end
`else
          bus.cnt_load_en = 1'b0;
          bus.cnt_down    = (op == OP_DOWN);
          if (rem == STEPW'(1)) begin
            state_nxt = DONE;
          end
`endif
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_cnt_arb_seq.sv
// Directed bench for cnt_arb_seq with a behavioural up/down counter attached.
module tb_cnt_arb_seq;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int STEPW = 4;
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  logic clk = 1'b0;
  logic rst;
  logic cnt_rst;
  logic [WIDTH-1:0] count;
  int checks = 0;
  int failures = 0;

  cnt_arb_seq_if #(.WIDTH(WIDTH), .NREQ(NREQ), .STEPW(STEPW)) bus();

  cnt_arb_seq #(.WIDTH(WIDTH), .NREQ(NREQ), .STEPW(STEPW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge cnt_rst) begin
    if (cnt_rst) begin
      count <= '0;
    end else if (bus.cnt_load_en) begin
      count <= bus.cnt_load;
    end else if (bus.cnt_down) begin
      count <= count - 1'b1;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bus.cnt_count    = count;
  assign bus.cnt_rollover = &count;

  task automatic set_req(input int i, input logic [1:0] op,
                         input logic [WIDTH-1:0] v, input logic [STEPW-1:0] s);
    bus.req_op[2*i +: 2]            = op;
    bus.req_val[WIDTH*i +: WIDTH]   = v;
    bus.req_steps[STEPW*i +: STEPW] = s;
  endtask

  // Issue one op, wait (bounded) for its done pulse, drop the op, return to IDLE.
  task automatic run_op(input int i, input logic [1:0] op,
                        input logic [WIDTH-1:0] v, input logic [STEPW-1:0] s,
                        output int cyc, output logic w, output logic [NREQ-1:0] d);
    cyc = -1;
    w   = 1'b0;
    d   = '0;
    set_req(i, op, v, s);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.done != '0) begin
        cyc = n;
        w   = bus.wrap;
        d   = bus.done;
        break;
      end
    end
    set_req(i, OP_NONE, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cnt_rst = 1'b1;
    bus.req_op = '0;
    bus.req_val = '0;
    bus.req_steps = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt_rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000 || bus.done !== 4'b0000 || bus.wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_outs: busy=%b gnt=%b done=%b wrap=%b expected 0 0000 0000 0", bus.busy, bus.gnt, bus.done, bus.wrap);
    end
    checks++;
    if (bus.cnt_load_en !== 1'b1 || bus.cnt_down !== 1'b0) begin
      failures++;
      $display("FAIL reset_cnt_ctl: load_en=%b down=%b expected 1 0", bus.cnt_load_en, bus.cnt_down);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (count !== 4'd0 || bus.cnt_load_en !== 1'b1 || bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
        failures++;
        $display("FAIL idle_hold c=%0d: count=%0d load_en=%b busy=%b gnt=%b expected 0 1 0 0000", c, count, bus.cnt_load_en, bus.busy, bus.gnt);
      end
    end
  endtask

  task automatic test_load();
    set_req(1, OP_LOAD, 4'd9, 4'd0);
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0010 || bus.busy !== 1'b1 || bus.done !== 4'b0000) begin
      failures++;
      $display("FAIL load_run: gnt=%b busy=%b done=%b expected 0010 1 0000", bus.gnt, bus.busy, bus.done);
    end
    checks++;
    if (bus.cnt_load_en !== 1'b1 || bus.cnt_load !== 4'd9) begin
      failures++;
      $display("FAIL load_drive: load_en=%b load=%0d expected 1 9", bus.cnt_load_en, bus.cnt_load);
    end
    @(negedge clk);
    checks++;
    if (count !== 4'd9 || bus.done !== 4'b0010 || bus.wrap !== 1'b0 || bus.gnt !== 4'b0010) begin
      failures++;
      $display("FAIL load_done: count=%0d done=%b wrap=%b gnt=%b expected 9 0010 0 0010", count, bus.done, bus.wrap, bus.gnt);
    end
    set_req(1, OP_NONE, '0, '0);
    @(negedge clk);
    checks++;
    if (bus.done !== 4'b0000 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL load_idle: done=%b busy=%b expected 0000 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_up_wrap();
    int cyc;
    logic w;
    logic [NREQ-1:0] d;
`ifdef CNT_ARB_SAT_EN
    int exp_cyc = 4;
    logic [WIDTH-1:0] exp_cnt = 4'd15;
`else
    int exp_cyc = 6;
    logic [WIDTH-1:0] exp_cnt = 4'd2;
`endif
    run_op(0, OP_LOAD, 4'd13, 4'd0, cyc, w, d);
    checks++;
    if (count !== 4'd13 || d !== 4'b0001 || cyc !== 2) begin
      failures++;
      $display("FAIL preload13: count=%0d done=%b cyc=%0d expected 13 0001 2", count, d, cyc);
    end
    run_op(2, OP_UP, 4'd0, 4'd5, cyc, w, d);
    checks++;
    if (cyc !== exp_cyc || d !== 4'b0100) begin
      failures++;
      $display("FAIL up_wrap_timing: cyc=%0d done=%b expected %0d 0100", cyc, d, exp_cyc);
    end
    checks++;
    if (count !== exp_cnt || w !== 1'b1) begin
      failures++;
      $display("FAIL up_wrap_result: count=%0d wrap=%b expected %0d 1", count, w, exp_cnt);
    end
  endtask

  task automatic test_zero_steps();
    int cyc;
    logic w;
    logic [NREQ-1:0] d;
    run_op(0, OP_LOAD, 4'd7, 4'd0, cyc, w, d);
    run_op(3, OP_UP, 4'd0, 4'd0, cyc, w, d);
    checks++;
    if (cyc !== 2 || d !== 4'b1000 || w !== 1'b0 || count !== 4'd7) begin
      failures++;
      $display("FAIL zero_steps: cyc=%0d done=%b wrap=%b count=%0d expected 2 1000 0 7", cyc, d, w, count);
    end
  endtask

  task automatic test_reset_mid_op();
    set_req(1, OP_UP, 4'd0, 4'd8);
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0010 || bus.cnt_load_en !== 1'b0 || bus.cnt_down !== 1'b0) begin
      failures++;
      $display("FAIL midop_run: gnt=%b load_en=%b down=%b expected 0010 0 0", bus.gnt, bus.cnt_load_en, bus.cnt_down);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.done !== 4'b0000 || bus.cnt_load_en !== 1'b1) begin
      failures++;
      $display("FAIL midop_async: gnt=%b busy=%b done=%b load_en=%b expected 0000 0 0000 1", bus.gnt, bus.busy, bus.done, bus.cnt_load_en);
    end
    set_req(1, OP_NONE, '0, '0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (count !== 4'd8 || bus.done !== 4'b0000) begin
        failures++;
        $display("FAIL midop_hold c=%0d: count=%0d done=%b expected 8 0000", c, count, bus.done);
      end
    end
    rst = 1'b0;
    set_req(0, OP_LOAD, 4'd5, 4'd0);
    set_req(3, OP_LOAD, 4'd11, 4'd0);
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0001) begin
      failures++;
      $display("FAIL post_rst_first: gnt=%b expected 0001", bus.gnt);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 4'b0001 || count !== 4'd5) begin
      failures++;
      $display("FAIL post_rst_done0: done=%b count=%0d expected 0001 5", bus.done, count);
    end
    set_req(0, OP_NONE, '0, '0);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b1000) begin
      failures++;
      $display("FAIL post_rst_second: gnt=%b expected 1000", bus.gnt);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 4'b1000 || count !== 4'd11) begin
      failures++;
      $display("FAIL post_rst_done3: done=%b count=%0d expected 1000 11", bus.done, count);
    end
    set_req(3, OP_NONE, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_rr_down();
`ifdef CNT_ARB_SAT_EN
    logic [WIDTH-1:0] exp_cnt [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic exp_wrap [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
    logic [WIDTH-1:0] exp_cnt [4] = '{4'd15, 4'd14, 4'd13, 4'd12};
    logic exp_wrap [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
`endif
    logic [NREQ-1:0] exp_done;
    int k;
    rst = 1'b1;
    cnt_rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt_rst = 1'b0;
    set_req(1, OP_DOWN, 4'd0, 4'd1);
    set_req(2, OP_DOWN, 4'd0, 4'd1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      k = (c - 2) / 3;
      exp_done = (c % 3 == 2) ? ((k % 2 == 0) ? 4'b0010 : 4'b0100) : 4'b0000;
      checks++;
      if (bus.done !== exp_done) begin
        failures++;
        $display("FAIL rr_done c=%0d: done=%b expected %b", c, bus.done, exp_done);
      end
      if (c % 3 == 2) begin
        checks++;
        if (count !== exp_cnt[k] || bus.wrap !== exp_wrap[k]) begin
          failures++;
          $display("FAIL rr_result op=%0d: count=%0d wrap=%b expected %0d %b", k, count, bus.wrap, exp_cnt[k], exp_wrap[k]);
        end
      end
    end
    set_req(1, OP_NONE, '0, '0);
    set_req(2, OP_NONE, '0, '0);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rr_idle: busy=%b expected 0", bus.busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_up_wrap();
    test_zero_steps();
    test_reset_mid_op();
    test_rr_down();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
